wrr_arb: RTL and testbench

WRR_ARB -- requirements
Module: wrr_arb

---
 rtl/wrr_arb_if.sv | 25 ++
 rtl/wrr_arb.sv | 156 +++++++++++++++
 tb/tb_wrr_arb.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wrr_arb_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface wrr_arb_if #(
   parameter int N = 4,
   parameter int W = 4
);
   localparam int IW = $clog2(N);

   logic [N-1:0]   req;
   logic [N*W-1:0] weight;
   logic           ack;
   logic [N-1:0]   grant;
   logic           grant_valid;
   logic [IW-1:0]  grant_id;

   modport master (
      output req, weight, ack,
      input  grant, grant_valid, grant_id
   );

   modport slave (
      input  req, weight, ack,
      output grant, grant_valid, grant_id
   );
endinterface

// File: rtl/wrr_arb.sv
// Weighted round-robin arbiter: one owner at a time keeps the grant for up to
// weight[owner] acknowledged transactions, then the grant rotates after ptr.
module wrr_arb #(
   parameter int N = 4,
   parameter int W = 4
) (
   input logic      clk,
   input logic      rst_n,
   wrr_arb_if.slave bus
);
   localparam int IW = $clog2(N);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   state_t        state_r;
   state_t        state_s;
   logic [IW-1:0] owner_r;
   logic [IW-1:0] owner_s;
   logic [IW-1:0] ptr_r;
   logic [IW-1:0] ptr_s;
   logic [W-1:0]  credit_r;
   logic [W-1:0]  credit_s;
   logic [N-1:0]  grant_r;
   logic [N-1:0]  grant_s;
   logic [IW-1:0] grant_id_r;
   logic [IW-1:0] grant_id_s;
   logic          grant_valid_r;
   logic          grant_valid_s;
   logic [N-1:0]  others_s;
   logic          own_req_s;
   logic [IW:0]   pick_s;

   // First set bit of cand after position from, wrapping; MSB flags a hit.
   // Scanning from the far end lets the nearest candidate win without a break.
   function automatic logic [IW:0] pick_next(input logic [N-1:0] cand,
                                             input logic [IW-1:0] from);
      logic [IW:0] res;
      int          idx;
      res = {(IW+1){1'b0}};
      for (int k = N; k >= 1; k--) begin
         idx = (int'(from) + k) % N;
         if (cand[idx]) begin
            res = {1'b1, IW'(idx)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   // Weight of requester id as a starting credit; a zero weight still earns one transaction.
   function automatic logic [W-1:0] load_credit(input logic [N*W-1:0] wv,
                                                input logic [IW-1:0] id);
      logic [W-1:0] w;
      w = wv[int'(id)*W +: W];
      if (w == {W{1'b0}}) begin
         return W'(1'b1);
      end else begin
         return w;
      end
   endfunction

   function automatic logic [N-1:0] to_onehot(input logic [IW-1:0] id);
      logic [N-1:0] v;
      v = {N{1'b0}};
      v[id] = 1'b1;
      return v;
   endfunction

   // Next-state logic: ownership hand-off, credit accounting and pointer update.
   always_comb begin
      state_s   = state_r;
      owner_s   = owner_r;
      credit_s  = credit_r;
      ptr_s     = ptr_r;
      own_req_s = bus.req[owner_r];
      others_s  = bus.req & ~to_onehot(owner_r);
      pick_s    = {(IW+1){1'b0}};
      case (state_r)
         IDLE: begin
            pick_s = pick_next(bus.req, ptr_r);
            if (pick_s[IW]) begin
               state_s  = OWN;
               owner_s  = pick_s[IW-1:0];
               credit_s = load_credit(bus.weight, pick_s[IW-1:0]);
            end else begin
               state_s = IDLE;
            end
         end
         OWN: begin
            if (bus.ack && own_req_s && (credit_r > W'(1'b1))) begin
               credit_s = credit_r - W'(1'b1);
            end else if (bus.ack || !own_req_s) begin
               // Release: rotate to the next other requester, else re-grant or go idle.
               ptr_s  = owner_r;
               pick_s = pick_next(others_s, owner_r);
               if (pick_s[IW]) begin
                  owner_s  = pick_s[IW-1:0];
                  credit_s = load_credit(bus.weight, pick_s[IW-1:0]);
               end else if (own_req_s) begin
                  credit_s = load_credit(bus.weight, owner_r);
               end else begin
                  state_s  = IDLE;
                  credit_s = {W{1'b0}};
               end
            end else begin
               credit_s = credit_r;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Grant outputs derived from the upcoming state so they can be registered.
   always_comb begin
      grant_s       = {N{1'b0}};
      grant_id_s    = {IW{1'b0}};
      grant_valid_s = 1'b0;
      if (state_s == OWN) begin
         grant_s       = to_onehot(owner_s);
         grant_id_s    = owner_s;
         grant_valid_s = 1'b1;
      end else begin
         grant_s       = {N{1'b0}};
         grant_id_s    = {IW{1'b0}};
         grant_valid_s = 1'b0;
      end
   end

   // State and output registers; reset leaves ptr at N-1 so requester 0 goes first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         owner_r       <= {IW{1'b0}};
         ptr_r         <= IW'(N-1);
         credit_r      <= {W{1'b0}};
         grant_r       <= {N{1'b0}};
         grant_id_r    <= {IW{1'b0}};
         grant_valid_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         owner_r       <= owner_s;
         ptr_r         <= ptr_s;
         credit_r      <= credit_s;
         grant_r       <= grant_s;
         grant_id_r    <= grant_id_s;
         grant_valid_r <= grant_valid_s;
      end
   end

   assign bus.grant       = grant_r;
   assign bus.grant_id    = grant_id_r;
   assign bus.grant_valid = grant_valid_r;
endmodule

// File: tb/tb_wrr_arb.sv
// Directed scenarios plus randomized traffic for wrr_arb, checked against a
// transaction-level model of owner, remaining credit and rotation pointer.
module tb_wrr_arb;
   localparam int N  = 4;
   localparam int W  = 4;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   wrr_arb_if #(.N(N), .W(W)) bus ();
   wrr_arb #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;
   int m_owner;
   int m_credit;
   int m_ptr;

   function automatic int eff_w(input logic [N*W-1:0] wv, input int i);
      int v;
      v = int'(wv[i*W +: W]);
      return (v == 0) ? 1 : v;
   endfunction

   task automatic model_reset();
      m_owner  = -1;
      m_credit = 0;
      m_ptr    = N - 1;
   endtask

   // Model of one clock edge given the inputs presented before it.
   task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] wv, input logic a);
      int  nxt;
      bit  own;
      if (m_owner < 0) begin
         for (int k = N; k >= 1; k--) begin
            if (r[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
         end
         if (r != 4'b0000) begin
            m_owner  = nxt;
            m_credit = eff_w(wv, nxt);
         end
      end else begin
         own = r[m_owner];
         if (a && own && m_credit > 1) begin
            m_credit = m_credit - 1;
         end else if (a || !own) begin
            m_ptr = m_owner;
            nxt   = -1;
            for (int k = N - 1; k >= 1; k--) begin
               if (r[(m_ptr + k) % N]) nxt = (m_ptr + k) % N;
            end
            if (nxt >= 0) begin
               m_owner  = nxt;
               m_credit = eff_w(wv, nxt);
            end else if (own) begin
               m_credit = eff_w(wv, m_owner);
            end else begin
               m_owner  = -1;
               m_credit = 0;
            end
         end
      end
   endtask

   task automatic check_out(input string tag);
      logic [N-1:0]  exp_grant;
      logic [IW-1:0] exp_id;
      logic          exp_valid;
      exp_grant = 4'b0000;
      exp_id    = 2'd0;
      exp_valid = 1'b0;
      if (m_owner >= 0) begin
         exp_grant[m_owner] = 1'b1;
         exp_id    = IW'(m_owner);
         exp_valid = 1'b1;
      end
      checks++;
      assert (bus.grant === exp_grant) else begin
         errors++;
         $error("FAIL %s grant: got %b expected %b", tag, bus.grant, exp_grant);
      end
      checks++;
      assert (bus.grant_valid === exp_valid) else begin
         errors++;
         $error("FAIL %s grant_valid: got %b expected %b", tag, bus.grant_valid, exp_valid);
      end
      checks++;
      assert (bus.grant_id === exp_id) else begin
         errors++;
         $error("FAIL %s grant_id: got %0d expected %0d", tag, bus.grant_id, exp_id);
      end
   endtask

   task automatic check_grant(input string tag, input logic [N-1:0] exp_grant);
      checks++;
      assert (bus.grant === exp_grant) else begin
         errors++;
         $error("FAIL %s fixed grant: got %b expected %b", tag, bus.grant, exp_grant);
      end
   endtask

   task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] wv, input logic a,
                        input string tag);
      bus.req    = r;
      bus.weight = wv;
      bus.ack    = a;
      model_step(r, wv, a);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n      = 1'b0;
      bus.req    = 4'b0000;
      bus.ack    = 1'b0;
      model_reset();
      #1;
      check_out(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   int            seq30[5] = '{0, 1, 2, 3, 0};
   int            seq31[8] = '{0, 0, 0, 1, 2, 2, 3, 0};
   logic [N-1:0]  rq;
   logic [N*W-1:0] rw;
   logic          ra;
   logic [IW-1:0] exp_id;

   initial begin
      rst_n      = 1'b0;
      bus.req    = 4'b0000;
      bus.weight = 16'h0000;
      bus.ack    = 1'b0;
      model_reset();
      #2;
      check_out("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Equal weights rotate every acked cycle.
      for (int i = 0; i < 5; i++) begin
         cycle(4'b1111, 16'h1111, 1'b1, "rr_w1");
         exp_id = IW'(seq30[i]);
         check_grant("rr_w1_seq", 4'b0001 << exp_id);
      end

      // Weights {3,1,2,1}.
      do_reset("reset_w");
      for (int i = 0; i < 8; i++) begin
         cycle(4'b1111, 16'h1213, 1'b1, "wrr");
         exp_id = IW'(seq31[i]);
         check_grant("wrr_seq", 4'b0001 << exp_id);
      end

      // Lone requester keeps the grant across credit reloads.
      do_reset("reset_solo");
      for (int i = 0; i < 6; i++) begin
         cycle(4'b0100, 16'h0200, 1'b1, "solo");
         check_grant("solo_fixed", 4'b0100);
      end

      // Withdrawal without ack hands over; no preemption while held.
      do_reset("reset_wd");
      cycle(4'b0010, 16'h1111, 1'b0, "wd_take");
      cycle(4'b1010, 16'h1111, 1'b0, "wd_hold");
      check_grant("no_preempt", 4'b0010);
      cycle(4'b1000, 16'h1111, 1'b0, "wd_drop");
      check_grant("wd_next", 4'b1000);
      cycle(4'b1010, 16'h1111, 1'b1, "wd_after");
      check_grant("wd_ptr", 4'b0010);

      // Weight 0 behaves as weight 1.
      do_reset("reset_w0");
      cycle(4'b0001, 16'h1110, 1'b0, "w0_take");
      cycle(4'b0001, 16'h1110, 1'b1, "w0_ack");
      check_grant("w0_regrant", 4'b0001);
      cycle(4'b0011, 16'h1110, 1'b1, "w0_rot");
      check_grant("w0_rot1", 4'b0010);
      cycle(4'b0011, 16'h1110, 1'b1, "w0_back");
      check_grant("w0_rot0", 4'b0001);

      // Reset during ownership drops grant at once.
      do_reset("reset_mid");
      cycle(4'b0100, 16'h5555, 1'b0, "mid_take");
      cycle(4'b0100, 16'h5555, 1'b1, "mid_hold");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_out("async_drop");
      check_grant("async_zero", 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      cycle(4'b1111, 16'h5555, 1'b0, "after_rst");
      check_grant("after_rst0", 4'b0001);

      // Randomized traffic with sticky requests so ownerships last.
      rq = 4'b0000;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
         rw = 16'($urandom);
         ra = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
         cycle(rq, rw, ra, "rand");
         checks++;
         assert (bus.grant_valid === (|bus.grant)) else begin
            errors++;
            $error("FAIL rand_valid: got %b expected %b", bus.grant_valid, |bus.grant);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
